// File: rtl/fea_pkg.sv
// Shared definitions for the feature-buffer window controller: state
// encoding, default frame geometry and the counter widths derived from it.
package fea_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } fea_state_e;

    localparam int ROW_DEF   = 240;
    localparam int COL_DEF   = 376;
    localparam int KSIZE_DEF = 11;

    localparam int ROW_W = $clog2(ROW_DEF);
    localparam int COL_W = $clog2(COL_DEF);

endpackage

// File: rtl/fea_raster_cnt.sv
// Raster position counter: column wraps at COLS-1 and bumps the row, the row
// wraps at ROWS-1. clr restarts at (0,0) and may coincide with adv, in which
// case the advancing pixel is taken as (0,0) and the counter lands on (0,1).
module fea_raster_cnt
    import fea_pkg::*;
#(
    parameter int ROWS = ROW_DEF,
    parameter int COLS = COL_DEF,
    parameter int RW   = ROW_W,
    parameter int CW   = COL_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          adv,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          wrap
);

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    logic [RW-1:0] row_q, row_d, row_base;
    logic [CW-1:0] col_q, col_d, col_base;

    // Next position: optional restart, then one raster step on adv.
    always_comb begin
        row_base = clr ? '0 : row_q;
        col_base = clr ? '0 : col_q;
        row_d    = row_base;
        col_d    = col_base;
        if (adv) begin
            if (col_base == COL_LAST) begin
                col_d = '0;
                row_d = (row_base == ROW_LAST) ? '0 : row_base + RW'(1);
            end else begin
                col_d = col_base + CW'(1);
            end
        end
    end

    // Position register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign wrap = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/fea_window_ctrl.sv
// Sequencer for the line-buffer chain: accepts the raster stream, drives the
// shared buffer advance, flags valid vertical windows with their coordinates
// and pads the bottom of the frame so every input row yields a window row.
//
// Handshakes: a beat transfers on a rising edge where valid and ready are both
// high. s_ready never depends on s_valid; win_valid, once high, holds with
// stable coordinates until m_ready is seen high.
module fea_window_ctrl
    import fea_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter int              ROW      = ROW_DEF,
    parameter int              COL      = COL_DEF,
    parameter int              KSIZE    = KSIZE_DEF,
    parameter int              PAD_ROWS = 10,
    parameter logic [WIDTH-1:0] PAD_VAL = '0
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic [WIDTH-1:0]        s_data,
    input  logic                    s_valid,
    input  logic                    s_sof,
    output logic                    s_ready,
    output logic                    buf_ce,
    output logic [WIDTH-1:0]        buf_din,
    input  logic                    m_ready,
    output logic                    win_valid,
    output logic [$clog2(ROW)-1:0]  win_row,
    output logic [$clog2(COL)-1:0]  win_col,
    output logic                    frame_done,
    output logic                    sof_err,
    output fea_state_e              dbg_state
);

    localparam int RW = $clog2(ROW);
    localparam int CW = $clog2(COL);

    localparam logic [CW-1:0] COL_LAST      = CW'(COL - 1);
    localparam logic [RW-1:0] FILL_LAST_ROW = RW'(KSIZE - 2);
    localparam logic [RW-1:0] PAD_LAST_ROW  = RW'((PAD_ROWS > 0) ? PAD_ROWS - 1 : 0);
    localparam logic          NO_PAD        = (PAD_ROWS == 0);

    fea_state_e    state_q, state_d;
    logic          live_q, live_d;
    logic          win_valid_q, win_valid_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic          last_sent_q, last_sent_d;
    logic          sof_err_q, sof_err_d;

    logic          ready, adv, win_load, pad_sel, in_clr, out_clr;
    logic [RW-1:0] in_row, out_row;
    logic [CW-1:0] in_col, out_col;
    logic          in_wrap, out_wrap, in_origin;

    // Input side: counts accepted pixels, then pad advances during flush.
    fea_raster_cnt #(.ROWS(ROW), .COLS(COL), .RW(RW), .CW(CW)) u_in_cnt (
        .clk   (clk),
        .rst_n (en),
        .clr   (in_clr),
        .adv   (adv),
        .row   (in_row),
        .col   (in_col),
        .wrap  (in_wrap)
    );

    // Output side: coordinate of the next window to be produced.
    fea_raster_cnt #(.ROWS(ROW), .COLS(COL), .RW(RW), .CW(CW)) u_out_cnt (
        .clk   (clk),
        .rst_n (en),
        .clr   (out_clr),
        .adv   (win_load),
        .row   (out_row),
        .col   (out_col),
        .wrap  (out_wrap)
    );

    assign in_origin = (in_row == '0) && (in_col == '0);

    // Next state, advance control and window output stage.
    always_comb begin
        state_d     = state_q;
        live_d      = 1'b1;
        win_valid_d = win_valid_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        last_sent_d = last_sent_q;
        sof_err_d   = 1'b0;
        ready       = 1'b0;
        adv         = 1'b0;
        win_load    = 1'b0;
        pad_sel     = 1'b0;
        in_clr      = 1'b0;
        out_clr     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Ready is held low for the first cycle out of reset.
                ready = live_q;
                if (s_valid && ready && s_sof) begin
                    adv     = 1'b1;
                    in_clr  = 1'b1;
                    out_clr = 1'b1;
                    state_d = ST_FILL;
                end
            end
            ST_FILL, ST_RUN: begin
                ready = (state_q == ST_FILL) ? 1'b1 : (!win_valid_q || m_ready);
                if (s_valid && ready) begin
                    adv = 1'b1;
                    if (s_sof && !in_origin) begin
                        // Early start of frame: this pixel becomes (0,0).
                        sof_err_d   = 1'b1;
                        win_valid_d = 1'b0;
                        in_clr      = 1'b1;
                        out_clr     = 1'b1;
                        state_d     = ST_FILL;
                    end else if (state_q == ST_FILL) begin
                        if (in_row == FILL_LAST_ROW && in_col == COL_LAST) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        win_load = 1'b1;
                        if (in_wrap) begin
                            state_d     = ST_FLUSH;
                            last_sent_d = NO_PAD;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                pad_sel = 1'b1;
                if (!last_sent_q) begin
                    if (!win_valid_q || m_ready) begin
                        adv      = 1'b1;
                        win_load = 1'b1;
                        // Stop at the pad count, and never run past the last
                        // window row even if PAD_ROWS is oversized.
                        if ((in_row == PAD_LAST_ROW && in_col == COL_LAST) || out_wrap) begin
                            last_sent_d = 1'b1;
                        end
                    end
                end else if (!win_valid_q || m_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                in_clr      = 1'b1;
                out_clr     = 1'b1;
                last_sent_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (win_load) begin
            win_valid_d = 1'b1;
            win_row_d   = out_row;
            win_col_d   = out_col;
        end else if (m_ready) begin
            win_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge en) begin
        if (!en) begin
            state_q     <= ST_IDLE;
            live_q      <= 1'b0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            last_sent_q <= 1'b0;
            sof_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            live_q      <= live_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            last_sent_q <= last_sent_d;
            sof_err_q   <= sof_err_d;
        end
    end

    assign s_ready    = ready;
    assign buf_ce     = adv;
    assign buf_din    = adv ? (pad_sel ? PAD_VAL : s_data) : '0;
    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = (state_q == ST_DONE);
    assign sof_err    = sof_err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fea_window_ctrl.sv
// Bench for fea_window_ctrl on a 16x8 frame with an 11-tap chain.
module tb_fea_window_ctrl;
    import fea_pkg::*;

    localparam int W = 7;   // {row[3:0], col[2:0]}

    logic       clk;
    logic       en;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_sof;
    logic       s_ready;
    logic       buf_ce;
    logic [7:0] buf_din;
    logic       m_ready;
    logic       win_valid;
    logic [3:0] win_row;
    logic [2:0] win_col;
    logic       frame_done;
    logic       sof_err;
    fea_state_e dbg_state;

    fea_window_ctrl #(
        .WIDTH(8), .ROW(16), .COL(8), .KSIZE(11), .PAD_ROWS(10), .PAD_VAL(8'h00)
    ) dut (
        .clk        (clk),
        .en         (en),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_sof      (s_sof),
        .s_ready    (s_ready),
        .buf_ce     (buf_ce),
        .buf_din    (buf_din),
        .m_ready    (m_ready),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done),
        .sof_err    (sof_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int win_cnt, pad_cnt, pad_bad, ce_cnt, done_cnt, sof_err_cnt;
    int first_win_pix, pix_acc, last_win;
    logic wv_at_err;
    int mr_mode = 0;   // 0: always ready, 1: random, 2: held low

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        win_cnt = 0; pad_cnt = 0; pad_bad = 0; ce_cnt = 0; done_cnt = 0;
        sof_err_cnt = 0; first_win_pix = -1; pix_acc = 0; last_win = -1;
        wv_at_err = 1'b1;
    endtask

    task automatic push_windows(input int n);
        for (int i = 0; i < n; i++) begin
            logic [3:0] r;
            logic [2:0] c;
            r = 4'(i / 8);
            c = 3'(i % 8);
            exp_q.push_back({r, c});
        end
    endtask

    // ---------------- consumer ready driver ----------------
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mr_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        clear_stats();
        forever begin
            @(negedge clk);
            if (en) begin
                if (buf_ce) begin
                    ce_cnt++;
                    if (dbg_state == ST_FLUSH) begin
                        pad_cnt++;
                        if (buf_din != 8'h00) pad_bad++;
                    end
                end
                if (frame_done) done_cnt++;
                if (sof_err) begin
                    sof_err_cnt++;
                    wv_at_err = win_valid;
                end
                if (win_valid && first_win_pix < 0) first_win_pix = pix_acc;
                if (win_valid && m_ready) begin
                    win_cnt++;
                    last_win = int'({win_row, win_col});
                    if (exp_q.size() == 0) check("win_extra", 1, 0);
                    else check("win_coord", {win_row, win_col}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        #2 en = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        @(negedge clk);
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Sends n pixels (sof on the first); after each transfer idles gap cycles.
    task automatic send_pixels(input int n, input int gap);
        logic acc;
        int guard;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_sof   = (i == 0);
            s_data  = 8'($urandom_range(1, 255));
            guard   = 0;
            acc     = 1'b0;
            while (!acc && guard < 1000) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            s_valid = 1'b0;
            s_sof   = 1'b0;
            if (!acc) begin
                check("s_accept_timeout", 0, 1);
                break;
            end
            if (i == 0) begin
                pix_acc       = 1;
                first_win_pix = -1;
            end else begin
                pix_acc++;
            end
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_done();
        int guard = 0;
        while (done_cnt == 0 && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        if (done_cnt == 0) check("done_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic frame_checks(input string tag, input int exp_win, input int exp_ce, input int exp_err);
        check({tag, "_win_count"},  win_cnt, exp_win);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_first_win"},  first_win_pix, 81);
        check({tag, "_last_win"},   last_win, (15 << 3) | 7);
        check({tag, "_pad_adv"},    pad_cnt, 80);
        check({tag, "_pad_value"},  pad_bad, 0);
        check({tag, "_buf_ce"},     ce_cnt, exp_ce);
        check({tag, "_done_pulse"}, done_cnt, 1);
        check({tag, "_sof_err"},    sof_err_cnt, exp_err);
        check({tag, "_end_state"},  int'(dbg_state), int'(ST_IDLE));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"},    s_ready, 0);
        check({tag, "_buf_ce"},     buf_ce, 0);
        check({tag, "_buf_din"},    buf_din, 0);
        check({tag, "_win_valid"},  win_valid, 0);
        check({tag, "_win_row"},    win_row, 0);
        check({tag, "_win_col"},    win_col, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_sof_err"},    sof_err, 0);
        check({tag, "_state"},      int'(dbg_state), int'(ST_IDLE));
    endtask

    // ---------------- IDLE / FILL entry vectors ----------------
    typedef struct {
        logic       v;
        logic       sof;
        logic [7:0] d;
        logic       e_ready;
        logic       e_ce;
        logic [7:0] e_din;
        logic       e_err;
        int         e_state;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 0};
        vecs[2] = '{1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 0};
        vecs[3] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0, 0};
        vecs[4] = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 8'h22, 1'b0, 0};
        vecs[5] = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 8'h33, 1'b0, 1};
        vecs[6] = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 8'h44, 1'b0, 1};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1};

        en = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = 8'h00;

        // Reset values while en is low.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Dropped non-sof pixels in IDLE, sof start, early sof in FILL.
        for (int i = 0; i < 8; i++) begin
            s_valid = vecs[i].v;
            s_sof   = vecs[i].sof;
            s_data  = vecs[i].d;
            @(negedge clk);
            check($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].e_ready);
            check($sformatf("vec%0d_buf_ce", i),  buf_ce,  vecs[i].e_ce);
            check($sformatf("vec%0d_buf_din", i), buf_din, vecs[i].e_din);
            check($sformatf("vec%0d_sof_err", i), sof_err, vecs[i].e_err);
            check($sformatf("vec%0d_state", i),   int'(dbg_state), vecs[i].e_state);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;

        // Full frame, consumer always ready.
        do_reset();
        clear_stats();
        push_windows(128);
        send_pixels(128, 0);
        wait_done();
        frame_checks("frame", 128, 208, 0);

        // Consumer stalls for 5 cycles mid-RUN.
        do_reset();
        clear_stats();
        push_windows(128);
        fork
            send_pixels(128, 0);
            begin
                int guard = 0;
                while (win_cnt < 20 && guard < 2000) begin
                    @(negedge clk);
                    guard++;
                end
                @(posedge clk);
                mr_mode = 2;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("hold_s_ready",   s_ready, 0);
                    check("hold_buf_ce",    buf_ce, 0);
                    check("hold_win_valid", win_valid, 1);
                    check("hold_window",    {win_row, win_col}, exp_q[0]);
                end
                @(posedge clk);
                mr_mode = 0;
            end
        join
        wait_done();
        frame_checks("stall", 128, 208, 0);

        // Early sof at input pixel (12,3): 19 windows, then a fresh frame.
        do_reset();
        clear_stats();
        push_windows(19);
        push_windows(128);
        send_pixels(99, 0);
        send_pixels(128, 0);
        wait_done();
        frame_checks("sof", 147, 99 + 208, 1);
        check("sof_win_valid_cleared", wv_at_err, 0);

        // Reset in the middle of the flush, then a clean frame.
        do_reset();
        clear_stats();
        push_windows(128);
        send_pixels(128, 0);
        begin
            int guard = 0;
            while (pad_cnt < 20 && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            check("flush_reached", int'(dbg_state), int'(ST_FLUSH));
        end
        @(negedge clk);
        #2 en = 1'b0;
        #1;
        check_reset_outputs("flush_reset");
        exp_q.delete();
        @(negedge clk);
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_stats();
        push_windows(128);
        send_pixels(128, 0);
        wait_done();
        frame_checks("after_reset", 128, 208, 0);

        // Gapped input and random consumer ready.
        do_reset();
        clear_stats();
        push_windows(128);
        mr_mode = 1;
        send_pixels(128, 2);
        wait_done();
        mr_mode = 0;
        frame_checks("random", 128, 208, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
